neander_mem_arbiter: RTL
========================

# neander_mem_arbiter

Two-requester arbiter that shares the single SPI memory controller between the NEANDER-X CPU core and the debug/program-loader port. It sits between the CPU's memory handshake (`mem_req`/`mem_ready`, 16-bit address, 16-bit data) and the SPI controller. It serialises whole accesses, one owner at a time, and enforces a bounded-latency timeout so a stuck controller cannot hang either side.

## Interface
- `TIMEOUT`, default 1023: cycles in ACCESS before abort; 0 disables the timeout.
- `DBG_PRIORITY`, default 1: 1 means debug wins simultaneous requests; 0 means round-robin.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU access request; held with its fields until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 16: word address.
- `cpu_wdata` in 16: write data.
- `cpu_rdata` out 16: read data; valid while `cpu_ready`=1 and held until the next CPU completion.
- `cpu_ready` out 1: one-cycle completion pulse.
- `dbg_req`, `dbg_we`, `dbg_addr[15:0]`, `dbg_wdata[15:0]`, `dbg_rdata[15:0]`, `dbg_ready`: same semantics as the CPU port, for the debug port.
- `mc_req` out 1: request to the SPI controller; held high until `mc_ready`.
- `mc_we` out 1: write strobe to the controller.
- `mc_addr` out 16: address to the controller.
- `mc_wdata` out 16: write data to the controller.
- `mc_rdata` in 16: read data from the controller; valid in the `mc_ready` cycle.
- `mc_ready` in 1: one-cycle completion pulse from the controller.
- `owner` out 1: current/last grant, 0 = CPU, 1 = debug.
- `busy` out 1: high in ACCESS and DONE.
- `timeout_err` out 1: sticky; set on abort, cleared only by reset.

## Operation
- FSM states: IDLE → ACCESS → DONE → IDLE.
- **IDLE**
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requests: if `DBG_PRIORITY`=1, grant debug. Otherwise grant the requester that is not `last_owner`.
  - On grant: latch we/addr/wdata of the winner into the `mc_*` registers, set `owner`, go to ACCESS.
- **ACCESS**
  - `mc_req`=1 and the `mc_*` outputs are stable.
  - On `mc_ready`: capture `mc_rdata` into the owner's rdata register (reads only; a write leaves rdata unchanged), drop `mc_req`, go to DONE.
  - Timeout: the cycle counter reaches `TIMEOUT` (≠0) without `mc_ready`. Then drop `mc_req`, load 16'hFFFF into the owner's rdata (reads only), set `timeout_err`, go to DONE.
- **DONE**
  - The owner's ready = 1 for exactly one cycle; update `last_owner`; go to IDLE.
  - The owner's `req` is ignored in this cycle, so a still-high stale request is not re-granted.
- The non-owner's request is never dropped. It is granted in the next IDLE, which bounds starvation to one access when `DBG_PRIORITY`=0.
- Requesters that change fields mid-access have no effect: the fields were latched at grant.
- `mc_ready` outside ACCESS is ignored.
- The timeout counter is 16 bits. It is cleared on entry to ACCESS and saturates.

## Timing
- Reset values:
  - state = IDLE
  - `mc_req`=0, `mc_we`=0, `mc_addr`=0, `mc_wdata`=0
  - `cpu_rdata`=0, `dbg_rdata`=0
  - `cpu_ready`=0, `dbg_ready`=0
  - `owner`=0, `last_owner`=1 (CPU wins the first round-robin tie)
  - `busy`=0, `timeout_err`=0
- Request seen high at edge N in IDLE → `mc_req` high from cycle N+1.
- `mc_ready` at cycle K → `mc_req` low at K+1 and requester ready high in cycle K+1. The next grant is possible at edge K+2, with `mc_req` high at K+3.
- Minimum requester-visible latency is 3 cycles when the controller's `mc_ready` arrives in the first ACCESS cycle.
- Timeout: abort after exactly `TIMEOUT` ACCESS cycles; ready follows on the next cycle.
- Asynchronous reset mid-ACCESS drops `mc_req` immediately. The downstream controller is reset by the same `rst_n`, so no abort protocol is needed.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `neander_mem_pkg`:
  - `arb_state_t` enum (IDLE, ACCESS, DONE)
  - `OWNER_CPU`/`OWNER_DBG` constants
  - `MEM_AW`=16, `MEM_DW`=16
  - `MEM_ERR_DATA`=16'hFFFF
- Single flat module; no sub-module warranted. The timeout counter is inline.

## Test plan
- **CPU read:** `cpu_req`=1, `cpu_addr`=16'h0123; the controller returns 16'hBEEF after 5 cycles → `mc_addr`=16'h0123, `mc_we`=0, `cpu_ready` one pulse, `cpu_rdata`=16'hBEEF, `dbg_ready` never asserts.
- **Simultaneous, priority:** `cpu_req` and `dbg_req` rise in the same cycle with `DBG_PRIORITY`=1 → debug is served first (`owner`=1), then the CPU. Exactly two `mc_req` pulses, with the CPU's `mc_addr` appearing second.
- **Round-robin:** with `DBG_PRIORITY`=0, both requesters held high for 4 accesses → grants alternate CPU, DBG, CPU, DBG.
- **Timeout:** with `TIMEOUT`=8, `mc_ready` is never driven → `mc_req` falls after 8 ACCESS cycles. `cpu_ready` pulses with `cpu_rdata`=16'hFFFF, and `timeout_err` stays 1 until `rst_n`.
- **Write with field glitch:** debug write to addr 16'h8000, data 16'h1234; `dbg_wdata` changes after grant → `mc_wdata` stays 16'h1234, and `dbg_rdata` is unchanged.
- **Reset mid-access:** `rst_n` asserted low in ACCESS → `mc_req`=0 immediately, all outputs return to reset values, and the first request after release is granted normally.

Source files
------------

// File: rtl/neander_mem_pkg.sv
// Shared types and constants for the NEANDER-X memory arbitration path.
package neander_mem_pkg;

  localparam int unsigned MEM_AW    = 16;
  localparam int unsigned MEM_DW    = 16;
  localparam int unsigned ARB_CNT_W = 16;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  // Returned to a reader whose access was aborted by the timeout.
  localparam logic [MEM_DW-1:0] MEM_ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // One memory command as latched at grant time.
  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/neander_mem_arbiter.sv
// Shares the single SPI memory controller between the CPU core and the
// debug/program-loader port. One whole access at a time, with a bounded
// ACCESS-phase timeout so a stuck controller cannot hang a requester.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cpu_req/we/addr/wdata       CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready        CPU read data (held) and completion pulse
//   dbg_*                       same for the debug port
//   mc_req/we/addr/wdata        request to the SPI controller
//   mc_rdata, mc_ready          controller read data and completion pulse
//   owner                       current/last grant (0 = CPU, 1 = debug)
//   busy                        high while in ACCESS or DONE
//   timeout_err                 sticky abort flag, cleared only by reset
module neander_mem_arbiter
  import neander_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 1023,
  parameter bit          DBG_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [MEM_DW-1:0] cpu_wdata,
  output logic [MEM_DW-1:0] cpu_rdata,
  output logic              cpu_ready,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [MEM_AW-1:0] dbg_addr,
  input  logic [MEM_DW-1:0] dbg_wdata,
  output logic [MEM_DW-1:0] dbg_rdata,
  output logic              dbg_ready,

  output logic              mc_req,
  output logic              mc_we,
  output logic [MEM_AW-1:0] mc_addr,
  output logic [MEM_DW-1:0] mc_wdata,
  input  logic [MEM_DW-1:0] mc_rdata,
  input  logic              mc_ready,

  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [ARB_CNT_W-1:0] TIMEOUT_LIM = ARB_CNT_W'(TIMEOUT);
  localparam bit                   TIMEOUT_EN  = (TIMEOUT != 0);

  arb_state_t           state;
  logic                 last_owner;
  logic [ARB_CNT_W-1:0] acc_cnt;

  logic     grant_cpu;
  logic     grant_dbg;
  mem_cmd_t cpu_cmd;
  mem_cmd_t dbg_cmd;
  mem_cmd_t win_cmd;
  logic     to_hit;

  assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  // Arbitration: only consulted in IDLE; a tie goes to debug under fixed
  // priority, otherwise to whichever port did not own the last access.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      if (DBG_PRIORITY || (last_owner == OWNER_CPU)) begin
        grant_dbg = 1'b1;
      end else begin
        grant_cpu = 1'b1;
      end
    end else if (dbg_req) begin
      grant_dbg = 1'b1;
    end else if (cpu_req) begin
      grant_cpu = 1'b1;
    end
  end

  assign win_cmd = grant_dbg ? dbg_cmd : cpu_cmd;

  // Counter is cleared on ACCESS entry, so it holds (n-1) in the n-th
  // ACCESS cycle; aborting at TIMEOUT-1 gives exactly TIMEOUT cycles.
  assign to_hit = TIMEOUT_EN && (acc_cnt == (TIMEOUT_LIM - ARB_CNT_W'(1)));

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mc_req      <= 1'b0;
      mc_we       <= 1'b0;
      mc_addr     <= '0;
      mc_wdata    <= '0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      cpu_ready   <= 1'b0;
      dbg_ready   <= 1'b0;
      owner       <= OWNER_CPU;
      last_owner  <= OWNER_DBG;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      acc_cnt     <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_cpu || grant_dbg) begin
            state    <= ACCESS;
            mc_req   <= 1'b1;
            mc_we    <= win_cmd.we;
            mc_addr  <= win_cmd.addr;
            mc_wdata <= win_cmd.wdata;
            owner    <= grant_dbg ? OWNER_DBG : OWNER_CPU;
            busy     <= 1'b1;
            acc_cnt  <= '0;
          end
        end

        ACCESS: begin
          if (acc_cnt != '1) begin
            acc_cnt <= acc_cnt + ARB_CNT_W'(1);
          end
          // A real completion wins over a coincident timeout.
          if (mc_ready || to_hit) begin
            mc_req <= 1'b0;
            state  <= DONE;
            if (!mc_ready) begin
              timeout_err <= 1'b1;
            end
            if (owner == OWNER_DBG) begin
              dbg_ready <= 1'b1;
              if (!mc_we) begin
                dbg_rdata <= mc_ready ? mc_rdata : MEM_ERR_DATA;
              end
            end else begin
              cpu_ready <= 1'b1;
              if (!mc_we) begin
                cpu_rdata <= mc_ready ? mc_rdata : MEM_ERR_DATA;
              end
            end
          end
        end

        // Ready pulse is visible this cycle; requests are not sampled here,
        // so a stale request still high from the owner is not re-granted.
        DONE: begin
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
